// File: rtl/rr_stream_mux.sv
// N-to-1 valid/ready stream mux with a one-beat registered output stage.
// Round-robin (MODE=0) or external select (MODE=1); packet lock via RR_MUX_PKT_LOCK_EN.
module rr_stream_mux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned MODE  = 0,
    localparam int unsigned SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   x_in,
    input  logic [NCH-1:0]         v_in,
    output logic [NCH-1:0]         r_out,
    input  logic [SEL_W-1:0]       sel_in,
`ifdef RR_MUX_PKT_LOCK_EN
    input  logic [NCH-1:0]         last_in,
    output logic                   m_last,
`endif
    output logic [WIDTH-1:0]       m_out,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [SEL_W-1:0]       m_chan
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] m_out_q, m_out_d;
    logic [SEL_W-1:0] m_chan_q, m_chan_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load_en;
    logic             xfer;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_last;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W-1:0] ptr_next;

    logic             hi_hit, lo_hit;
    logic [SEL_W-1:0] hi_idx, lo_idx;

    logic             lock_act;
    logic [SEL_W-1:0] lock_sel;

`ifdef RR_MUX_PKT_LOCK_EN
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic             m_last_q, m_last_d;

    assign lock_act = lock_q;
    assign lock_sel = lock_ch_q;
    assign m_last   = m_last_q;

    // End-of-packet flag of the granted channel.
    always_comb begin
        grant_last = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_last = last_in[i];
            end
        end
    end

    always_comb begin
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        m_last_d  = m_last_q;
        if (xfer) begin
            lock_d    = !grant_last;
            lock_ch_d = grant_idx;
            m_last_d  = grant_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
            m_last_q  <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
            m_last_q  <= m_last_d;
        end
    end
`else
    // Without packet lock every beat is treated as end-of-packet.
    assign lock_act   = 1'b0;
    assign lock_sel   = '0;
    assign grant_last = 1'b1;
`endif

    assign m_valid = (state_q == FULL);
    assign m_out   = m_out_q;
    assign m_chan  = m_chan_q;

    assign load_en = (state_q == EMPTY) || m_ready;
    assign xfer    = load_en && grant_valid;

    // First valid at or above ptr, and first valid overall for the wrapped search.
    always_comb begin
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_hit = 1'b0;
        lo_idx = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (v_in[i] && !lo_hit) begin
                lo_hit = 1'b1;
                lo_idx = SEL_W'(i);
            end
            if (v_in[i] && !hi_hit && (i >= 32'(ptr_q))) begin
                hi_hit = 1'b1;
                hi_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (lock_act) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if ((lock_sel == SEL_W'(i)) && v_in[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(i);
                end
            end
        end else if (MODE == 0) begin
            grant_valid = hi_hit || lo_hit;
            grant_idx   = hi_hit ? hi_idx : lo_idx;
        end else begin
            // Out-of-range selects match no channel and yield no grant.
            for (int unsigned i = 0; i < NCH; i++) begin
                if ((sel_in == SEL_W'(i)) && v_in[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = x_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        r_out = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!rst && xfer && (grant_idx == SEL_W'(i))) begin
                r_out[i] = 1'b1;
            end
        end
    end

    assign ptr_next = (grant_idx == SEL_W'(NCH - 1)) ? '0 : grant_idx + SEL_W'(1);

    // Output buffer FSM: load on transfer, drain to EMPTY when load_en finds no grant.
    always_comb begin
        state_d  = state_q;
        m_out_d  = m_out_q;
        m_chan_d = m_chan_q;
        ptr_d    = ptr_q;
        case (state_q)
            EMPTY, FULL: begin
                if (load_en) begin
                    if (grant_valid) begin
                        state_d  = FULL;
                        m_out_d  = grant_data;
                        m_chan_d = grant_idx;
                        if ((MODE == 0) && grant_last) begin
                            ptr_d = ptr_next;
                        end
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            m_out_q  <= '0;
            m_chan_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            m_out_q  <= m_out_d;
            m_chan_q <= m_chan_d;
            ptr_q    <= ptr_d;
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: vector table, hand-written corner sequences and randomized
// traffic on three configurations compared against a behavioural model.
module tb_rr_stream_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Config A: NCH=4 MODE=0
    logic [31:0] x_a;
    logic [3:0]  v_a, r_a, last_a;
    logic [1:0]  sel_a, chan_a;
    logic [7:0]  out_a;
    logic        val_a, rdy_a, m_last_a;
    // Config B: NCH=3 MODE=1
    logic [23:0] x_b;
    logic [2:0]  v_b, r_b, last_b;
    logic [1:0]  sel_b, chan_b;
    logic [7:0]  out_b;
    logic        val_b, rdy_b, m_last_b;
    // Config C: NCH=1 MODE=0
    logic [7:0]  x_c;
    logic [0:0]  v_c, r_c, last_c, sel_c, chan_c;
    logic [7:0]  out_c;
    logic        val_c, rdy_c, m_last_c;

    rr_stream_mux #(.WIDTH(8), .NCH(4), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .x_in(x_a), .v_in(v_a), .r_out(r_a), .sel_in(sel_a),
`ifdef RR_MUX_PKT_LOCK_EN
        .last_in(last_a), .m_last(m_last_a),
`endif
        .m_out(out_a), .m_valid(val_a), .m_ready(rdy_a), .m_chan(chan_a)
    );

    rr_stream_mux #(.WIDTH(8), .NCH(3), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .x_in(x_b), .v_in(v_b), .r_out(r_b), .sel_in(sel_b),
`ifdef RR_MUX_PKT_LOCK_EN
        .last_in(last_b), .m_last(m_last_b),
`endif
        .m_out(out_b), .m_valid(val_b), .m_ready(rdy_b), .m_chan(chan_b)
    );

    rr_stream_mux #(.WIDTH(8), .NCH(1), .MODE(0)) u_c (
        .clk(clk), .rst(rst), .x_in(x_c), .v_in(v_c), .r_out(r_c), .sel_in(sel_c),
`ifdef RR_MUX_PKT_LOCK_EN
        .last_in(last_c), .m_last(m_last_c),
`endif
        .m_out(out_c), .m_valid(val_c), .m_ready(rdy_c), .m_chan(chan_c)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    // Behavioural model: buffer contents, arbitration pointer and packet lock.
    typedef struct {
        logic       valid;
        logic [7:0] data;
        int         chan;
        int         ptr;
        logic       lock;
        int         lock_ch;
        logic       last;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.valid = 1'b0; m.data = 8'h00; m.chan = 0; m.ptr = 0;
        m.lock = 1'b0; m.lock_ch = 0; m.last = 1'b0;
        return m;
    endfunction

    function automatic int mdl_grant(mdl_t m, int nch, int mode, logic [3:0] v, int sel);
        if (m.lock) return v[m.lock_ch] ? m.lock_ch : -1;
        if (mode == 1) return ((sel < nch) && v[sel]) ? sel : -1;
        for (int k = 0; k < nch; k++) begin
            int i;
            i = (m.ptr + k) % nch;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] mdl_r(mdl_t m, int nch, int mode, logic [3:0] v, int sel,
                                         logic rdy);
        int g;
        g = mdl_grant(m, nch, mode, v, sel);
        if ((!m.valid || rdy) && (g >= 0)) return 4'(1) << g;
        return 4'b0000;
    endfunction

    function automatic void mdl_step(inout mdl_t m, input int nch, input int mode,
                                     input logic [3:0] v, input int sel, input logic [3:0] last,
                                     input logic rdy, input logic [31:0] xs);
        int g;
        if (m.valid && !rdy) return;
        g = mdl_grant(m, nch, mode, v, sel);
        if (g < 0) begin
            m.valid = 1'b0;
            return;
        end
        m.valid = 1'b1;
        m.data  = xs[g*8 +: 8];
        m.chan  = g;
        m.last  = last[g];
`ifdef RR_MUX_PKT_LOCK_EN
        if (!last[g]) begin
            m.lock = 1'b1;
            m.lock_ch = g;
        end else begin
            m.lock = 1'b0;
            if (mode == 0) m.ptr = (g + 1) % nch;
        end
`else
        if (mode == 0) m.ptr = (g + 1) % nch;
`endif
    endfunction

    typedef struct {
        logic [3:0] v;
        logic       rdy;
        logic [3:0] r;
        logic       val;
        logic [1:0] chan;
        logic [7:0] out;
    } vec_t;

    function automatic vec_t mk(logic [3:0] v, logic rdy, logic [3:0] r, logic val,
                                logic [1:0] chan, logic [7:0] out);
        vec_t t;
        t.v = v; t.rdy = rdy; t.r = r; t.val = val; t.chan = chan; t.out = out;
        return t;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        v_a = '0; v_b = '0; v_c = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vec_t tbl[$];
        mdl_t ma, mb, mc;
        logic [1:0] exp_ch[4];
        logic       exp_last[4];

        rst = 1'b1;
        x_a = 32'hA3A2A1A0; v_a = 4'hF; rdy_a = 1'b1; sel_a = '0; last_a = 4'hF;
        x_b = 24'hC2C1C0;   v_b = '0;   rdy_b = 1'b1; sel_b = '0; last_b = 3'h7;
        x_c = 8'h55;        v_c = '0;   rdy_c = 1'b1; sel_c = '0; last_c = 1'b1;

        // Reset state, with valids present to confirm ready stays low.
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_valid", 32'(val_a), 32'(0));
        chk("rst_out",   32'(out_a), 32'(0));
        chk("rst_chan",  32'(chan_a), 32'(0));
        chk("rst_ready", 32'(r_a), 32'(0));
        rst = 1'b0;
        v_a = '0;

        // Fairness, backpressure, sparse wrap, drain.
        tbl.push_back(mk(4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0));
        tbl.push_back(mk(4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1));
        tbl.push_back(mk(4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2));
        tbl.push_back(mk(4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3));
        tbl.push_back(mk(4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0));
        tbl.push_back(mk(4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0));
        tbl.push_back(mk(4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0));
        tbl.push_back(mk(4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0));
        tbl.push_back(mk(4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1));
        tbl.push_back(mk(4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3));
        tbl.push_back(mk(4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1));
        tbl.push_back(mk(4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3));
        tbl.push_back(mk(4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1));
        tbl.push_back(mk(4'h0, 1'b1, 4'b0000, 1'b0, 2'd1, 8'hA1));
        tbl.push_back(mk(4'h0, 1'b0, 4'b0000, 1'b0, 2'd1, 8'hA1));

        foreach (tbl[k]) begin
            @(negedge clk);
            v_a = tbl[k].v;
            rdy_a = tbl[k].rdy;
            #1;
            chk($sformatf("tbl%0d_ready", k), 32'(r_a), 32'(tbl[k].r));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_valid", k), 32'(val_a), 32'(tbl[k].val));
            chk($sformatf("tbl%0d_chan", k), 32'(chan_a), 32'(tbl[k].chan));
            chk($sformatf("tbl%0d_out", k), 32'(out_a), 32'(tbl[k].out));
        end

        // Asynchronous reset while a beat is buffered.
        @(negedge clk);
        v_a = 4'b0100; rdy_a = 1'b1;
        @(posedge clk); #1;
        chk("pre_arst_chan", 32'(chan_a), 32'(2));
        @(negedge clk);
        v_a = 4'hF; rdy_a = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(val_a), 32'(0));
        chk("arst_out",   32'(out_a), 32'(0));
        chk("arst_chan",  32'(chan_a), 32'(0));
        chk("arst_ready", 32'(r_a), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        rdy_a = 1'b1;
        #1;
        chk("post_rst_ready", 32'(r_a), 32'(4'b0001));
        @(posedge clk); #1;
        chk("post_rst_chan", 32'(chan_a), 32'(0));
        chk("post_rst_out",  32'(out_a), 32'(8'hA0));

        // External select: in-range, then out-of-range select drains the buffer.
        @(negedge clk);
        v_b = 3'b111; sel_b = 2'd2; rdy_b = 1'b1;
        #1;
        chk("sel2_ready", 32'(r_b), 32'(3'b100));
        @(posedge clk); #1;
        chk("sel2_chan", 32'(chan_b), 32'(2));
        chk("sel2_out",  32'(out_b), 32'(8'hC2));
        @(negedge clk);
        sel_b = 2'd3;
        #1;
        chk("sel3_ready", 32'(r_b), 32'(0));
        @(posedge clk); #1;
        chk("sel3_valid", 32'(val_b), 32'(0));
        chk("sel3_out_hold", 32'(out_b), 32'(8'hC2));

        // Packet lock: ch0 sends three beats with last on the third while ch1 waits.
`ifdef RR_MUX_PKT_LOCK_EN
        exp_ch = '{2'd0, 2'd0, 2'd0, 2'd1};
        exp_last = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
        exp_ch = '{2'd0, 2'd1, 2'd0, 2'd1};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        pulse_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            v_a = 4'b0011; rdy_a = 1'b1;
            last_a = {3'b111, (c == 2)};
            @(posedge clk); #1;
            chk($sformatf("pkt%0d_chan", c), 32'(chan_a), 32'(exp_ch[c]));
`ifdef RR_MUX_PKT_LOCK_EN
            chk($sformatf("pkt%0d_last", c), 32'(m_last_a), 32'(exp_last[c]));
`endif
        end

        // Randomized traffic on all three configurations.
        pulse_reset();
        ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            v_a = 4'($urandom); x_a = $urandom; rdy_a = ($urandom_range(0, 3) != 0);
            sel_a = 2'($urandom);
            for (int i = 0; i < 4; i++) last_a[i] = ($urandom_range(0, 2) != 0);
            v_b = 3'($urandom); x_b = 24'($urandom); rdy_b = ($urandom_range(0, 3) != 0);
            sel_b = 2'($urandom);
            for (int i = 0; i < 3; i++) last_b[i] = ($urandom_range(0, 2) != 0);
            v_c = 1'($urandom); x_c = 8'($urandom); rdy_c = ($urandom_range(0, 1) != 0);
            sel_c = 1'($urandom); last_c = ($urandom_range(0, 2) != 0);
            #1;
            chk("rnd_a_ready", 32'(r_a), 32'(mdl_r(ma, 4, 0, v_a, int'(sel_a), rdy_a)));
            chk("rnd_b_ready", 32'(r_b), 32'(mdl_r(mb, 3, 1, {1'b0, v_b}, int'(sel_b), rdy_b)));
            chk("rnd_c_ready", 32'(r_c), 32'(mdl_r(mc, 1, 0, {3'b0, v_c}, int'(sel_c), rdy_c)));
            mdl_step(ma, 4, 0, v_a, int'(sel_a), last_a, rdy_a, x_a);
            mdl_step(mb, 3, 1, {1'b0, v_b}, int'(sel_b), {1'b0, last_b}, rdy_b, {8'h00, x_b});
            mdl_step(mc, 1, 0, {3'b0, v_c}, int'(sel_c), {3'b0, last_c}, rdy_c, {24'h0, x_c});
            @(posedge clk); #1;
            chk("rnd_a_valid", 32'(val_a), 32'(ma.valid));
            chk("rnd_a_chan",  32'(chan_a), 32'(ma.chan));
            chk("rnd_a_out",   32'(out_a), 32'(ma.data));
            chk("rnd_b_valid", 32'(val_b), 32'(mb.valid));
            chk("rnd_b_chan",  32'(chan_b), 32'(mb.chan));
            chk("rnd_b_out",   32'(out_b), 32'(mb.data));
            chk("rnd_c_valid", 32'(val_c), 32'(mc.valid));
            chk("rnd_c_chan",  32'(chan_c), 32'(mc.chan));
            chk("rnd_c_out",   32'(out_c), 32'(mc.data));
`ifdef RR_MUX_PKT_LOCK_EN
            chk("rnd_a_last",  32'(m_last_a), 32'(ma.last));
            chk("rnd_b_last",  32'(m_last_b), 32'(mb.last));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
